data_mem_ctrl: RTL and testbench

//  Parametrised data memory with request/response handshake and programmable wait states.

---
 rtl/data_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data memory controller: request/response handshake, programmable wait states, range/alignment errors.
// Optional DMEM_BYTE_LANE_EN enables byte/half accesses with sign/zero extension; otherwise word-only.
module data_mem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  output logic              Ready,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              RespValid,
  output logic [31:0]       ReadData,
  output logic              Err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [DEPTH];

  logic          accept, access, oor, mis, err_c;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rdword, wword, ldata;

  assign Ready  = (state == IDLE) && !Rst;
  assign accept = Req && Ready;
  assign access = (state == WAIT) && (cnt == 4'd0);
  assign idx    = addr_q[AW+1:2];
  assign lane   = addr_q[1:0];
  assign rdword = mem[idx];
  assign oor    = {1'b0, addr_q} >= LIMIT;
  assign err_c  = mis || oor;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DMEM_BYTE_LANE_EN
  logic [1:0]  size_q;
  logic        uns_q;
  logic [3:0]  wmask;
  logic [31:0] wrep, bsel;
  logic [15:0] hsel;

  always_comb begin
    wmask = 4'hF;
    wrep  = wdata_q;
    mis   = 1'b0;
    case (size_q)
      2'b00: begin
        wmask = 4'b0001 << lane;
        wrep  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wmask = lane[1] ? 4'b1100 : 4'b0011;
        wrep  = {2{wdata_q[15:0]}};
        mis   = lane[0];
      end
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    for (int i = 0; i < 4; i++)
      wword[8*i +: 8] = wmask[i] ? wrep[8*i +: 8] : rdword[8*i +: 8];
  end

  always_comb begin
    bsel  = rdword >> {lane, 3'b000};
    hsel  = lane[1] ? rdword[31:16] : rdword[15:0];
    ldata = rdword;
    case (size_q)
      2'b00:   ldata = uns_q ? {24'd0, bsel[7:0]} : {{24{bsel[7]}}, bsel[7:0]};
      2'b01:   ldata = uns_q ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
      default: ldata = rdword;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      size_q <= 2'b10;
      uns_q  <= 1'b0;
    end else if (accept) begin
      size_q <= Size;
      uns_q  <= Unsigned;
    end
  end
`else
  logic unused_lane_ins;
  assign unused_lane_ins = ^{Size, Unsigned};
  assign mis   = (lane != 2'b00);
  assign wword = wdata_q;
  assign ldata = rdword;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      RespValid <= 1'b0;
      ReadData  <= 32'd0;
      Err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      RespValid <= access;
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        we_q    <= MemWrite;
        addr_q  <= Address;
        wdata_q <= WriteData;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        ReadData <= (err_c || we_q) ? 32'd0 : ldata;
        Err      <= err_c;
      end
    end
  end

  // Array has no reset; a reset during WAIT forces IDLE so the pending store never fires.
  always_ff @(posedge Clk) begin
    if (access && we_q && !err_c)
      mem[idx] <= wword;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: main instance with WAIT_CYCLES=1, plus 0 and 3 for spacing.
module tb_data_mem_ctrl;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Req = 1'b0, Req0 = 1'b0, Req3 = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Size = 2'b10;
  logic        Unsigned = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        ready, resp_valid, err;
  logic [31:0] read_data;
  logic        ready0, rv0, er0, ready3, rv3, er3;
  logic [31:0] rd0, rd3;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1), .ADDR_W(32)) u1 (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Ready(ready), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .RespValid(resp_valid), .ReadData(read_data), .Err(err));
  data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0), .ADDR_W(32)) u0 (
    .Clk(Clk), .Rst(Rst), .Req(Req0), .Ready(ready0), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .RespValid(rv0), .ReadData(rd0), .Err(er0));
  data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(3), .ADDR_W(32)) u3 (
    .Clk(Clk), .Rst(Rst), .Req(Req3), .Ready(ready3), .MemWrite(MemWrite), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .RespValid(rv3), .ReadData(rd3), .Err(er3));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One transaction on u1; lat counts falling edges from the one after accept to RespValid.
  task automatic xact(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    @(negedge Clk);
    Req = 1'b1; MemWrite = we; Size = sz; Unsigned = un; Address = a; WriteData = wd;
    @(negedge Clk);
    Req = 1'b0; MemWrite = 1'b0; Address = 32'hFFFF_FFFF; WriteData = 32'h5A5A_5A5A;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge Clk);
      lat++;
    end
    rd = read_data;
    er = err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          p0 [2];
  int          p3 [2];
  int          n0, n3, r0, r3;
  logic        rv0_h [41];
  logic        rv3_h [41];
  logic        rdy0_h [41];
  logic        rdy3_h [41];

  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_respvalid", {31'd0, resp_valid}, 32'd0);
    chk("rst_readdata", read_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    xact(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, rd, er, lat);
    chk("st_word_lat", 32'(lat), 32'd2);
    chk("st_word_err", {31'd0, er}, 32'd0);
    chk("st_word_rd", rd, 32'd0);
    xact(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("ld_word_8", rd, 32'hDEADBEEF);

    xact(1'b1, 2'b10, 1'b0, 32'd8, 32'd0, rd, er, lat);
    xact(1'b1, 2'b00, 1'b0, 32'd9, 32'h0000_0080, rd, er, lat);
`ifdef DMEM_BYTE_LANE_EN
    chk("st_byte_err", {31'd0, er}, 32'd0);
    xact(1'b0, 2'b00, 1'b0, 32'd9, 32'd0, rd, er, lat);
    chk("ld_byte_s", rd, 32'hFFFF_FF80);
    xact(1'b0, 2'b00, 1'b1, 32'd9, 32'd0, rd, er, lat);
    chk("ld_byte_u", rd, 32'h0000_0080);
    xact(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("ld_word_merge", rd, 32'h0000_8000);
    xact(1'b1, 2'b01, 1'b0, 32'd10, 32'h1234_A5C3, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("ld_word_half", rd, 32'hA5C3_8000);
    xact(1'b0, 2'b01, 1'b0, 32'd10, 32'd0, rd, er, lat);
    chk("ld_half_s", rd, 32'hFFFF_A5C3);
    xact(1'b0, 2'b01, 1'b1, 32'd10, 32'd0, rd, er, lat);
    chk("ld_half_u", rd, 32'h0000_A5C3);
    xact(1'b0, 2'b11, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("size11_err", {31'd0, er}, 32'd1);
    chk("size11_rd", rd, 32'd0);
`else
    chk("st_byte_err", {31'd0, er}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("ld_word_nomerge", rd, 32'd0);
`endif

    xact(1'b1, 2'b10, 1'b0, 32'd4, 32'h1234_5678, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'd6, 32'd0, rd, er, lat);
    chk("mis_word_err", {31'd0, er}, 32'd1);
    chk("mis_word_rd", rd, 32'd0);
    xact(1'b0, 2'b01, 1'b0, 32'd5, 32'd0, rd, er, lat);
    chk("mis_half_err", {31'd0, er}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'd4096, 32'd0, rd, er, lat);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_rd", rd, 32'd0);
    xact(1'b1, 2'b10, 1'b0, 32'd6, 32'hFFFF_FFFF, rd, er, lat);
    chk("mis_st_err", {31'd0, er}, 32'd1);
    xact(1'b1, 2'b10, 1'b0, 32'd4100, 32'hFFFF_FFFF, rd, er, lat);
    chk("oor_st_err", {31'd0, er}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'd4, 32'd0, rd, er, lat);
    chk("mem_unchanged", rd, 32'h1234_5678);
    chk("err_clear", {31'd0, er}, 32'd0);

    xact(1'b1, 2'b10, 1'b0, 32'd16, 32'h1111_1111, rd, er, lat);
    xact(1'b0, 2'b10, 1'b0, 32'd16, 32'd0, rd, er, lat);
    repeat (3) @(negedge Clk);
    chk("rd_hold", read_data, 32'h1111_1111);
    Req = 1'b1; MemWrite = 1'b1; Size = 2'b10; Address = 32'd16; WriteData = 32'h2222_2222;
    @(negedge Clk);
    Req = 1'b0; MemWrite = 1'b0;
    Rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rv", {31'd0, resp_valid}, 32'd0);
    chk("midrst_rd", read_data, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'd16, 32'd0, rd, er, lat);
    chk("abort_no_write", rd, 32'h1111_1111);

    @(negedge Clk);
    MemWrite = 1'b1; Size = 2'b10; Address = 32'd0; WriteData = 32'hCAFE_0000;
    Req0 = 1'b1; Req3 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      rv0_h[i] = rv0; rdy0_h[i] = ready0;
      rv3_h[i] = rv3; rdy3_h[i] = ready3;
    end
    Req0 = 1'b0; Req3 = 1'b0;
    p0[0] = -1; p0[1] = -1; p3[0] = -1; p3[1] = -1;
    n0 = 0; n3 = 0;
    for (int i = 1; i <= 40; i++) begin
      if (rv0_h[i] && n0 < 2) begin p0[n0] = i; n0++; end
      if (rv3_h[i] && n3 < 2) begin p3[n3] = i; n3++; end
    end
    chk("w0_first", 32'(p0[0]), 32'd2);
    chk("w3_first", 32'(p3[0]), 32'd5);
    chk("w0_spacing", 32'(p0[1] - p0[0]), 32'd3);
    chk("w3_spacing", 32'(p3[1] - p3[0]), 32'd6);
    r0 = 0; r3 = 0;
    for (int i = 1; i <= 40; i++) begin
      if (p0[0] > 0 && i > p0[0] && i < p0[1] && rdy0_h[i]) r0++;
      if (p3[0] > 0 && i > p3[0] && i < p3[1] && rdy3_h[i]) r3++;
    end
    chk("w0_ready_gap", 32'(r0), 32'd1);
    chk("w3_ready_gap", 32'(r3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
